// File: rtl/plru_set_array.sv
// plru_set_array: per-set tree pseudo-LRU victim selection with invalid-way priority, locking and flush
module plru_set_array #(
  parameter int SETS              = 16,
  parameter int WAYS              = 4,
  parameter int UPDATE_ON_REPLACE = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    acc_valid_i,
  input  logic [$clog2(SETS)-1:0] acc_set_i,
  input  logic [$clog2(WAYS)-1:0] acc_way_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [$clog2(SETS)-1:0] req_set_i,
  input  logic [WAYS-1:0]         req_valid_mask_i,
  input  logic [WAYS-1:0]         req_lock_mask_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [$clog2(WAYS)-1:0] rsp_way_o,
  output logic                    rsp_none_o,
  input  logic                    flush_i,
  output logic                    flush_busy_o
);
  localparam int SW    = $clog2(SETS);
  localparam int WW    = $clog2(WAYS);
  localparam int NODES = WAYS - 1;
  typedef enum logic {IDLE, FLUSH} state_e;
  state_e           state_q, state_d;
  logic [SW-1:0]    cnt_q;
  logic [NODES-1:0] tree_q [SETS];
  logic [NODES-1:0] tree_d [SETS];
  logic [WW-1:0]    victim;
  logic             none, idle, accept, fill;

  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t, input logic [WW-1:0] way);
    logic [NODES-1:0] r;
    r = t;
    for (int l = 0; l < WW; l++)
      for (int k = 0; k < NODES; k++)
        if (k == (1 << l) - 1 + int'(way >> (WW - l))) r[k] = !way[WW-1-l];
    return r;
  endfunction

  function automatic logic [WW-1:0] walk(input logic [NODES-1:0] t, input logic [WAYS-1:0] lock);
    int   pfx;
    logic dir, all_lk;
    pfx = 0;
    for (int l = 0; l < WW; l++) begin
      dir = 1'b0;
      for (int k = 0; k < NODES; k++)
        if (k == (1 << l) - 1 + pfx) dir = t[k];
      all_lk = 1'b1;
      for (int w = 0; w < WAYS; w++)
        if ((w >> (WW - 1 - l)) == 2 * pfx + int'(dir) && !lock[w]) all_lk = 1'b0;
      pfx = 2 * pfx + int'(dir ^ all_lk);
    end
    return WW'(pfx);
  endfunction

  assign idle         = state_q == IDLE;
  assign flush_busy_o = !idle;
  assign req_ready_o  = idle && (!rsp_valid_o || rsp_ready_i);
  assign accept       = req_valid_i && req_ready_o;
  assign none         = &req_lock_mask_i;
  assign fill         = accept && !none && (UPDATE_ON_REPLACE != 0);
  assign state_d      = idle ? (flush_i ? FLUSH : IDLE) : (cnt_q == SW'(SETS - 1) ? IDLE : FLUSH);

  // victim: lowest invalid unlocked way, else lock-aware tree walk, forced to 0 when everything is locked
  always_comb begin
    victim = walk(tree_q[req_set_i], req_lock_mask_i);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!req_valid_mask_i[w] && !req_lock_mask_i[w]) victim = WW'(w);
    victim = none ? '0 : victim;
  end

  // next trees: flush clear, then fill update, then access update so the access wins on shared nodes
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      tree_d[s] = (!idle && cnt_q == SW'(s)) ? '0 : tree_q[s];
      tree_d[s] = (fill && req_set_i == SW'(s)) ? touch(tree_d[s], victim) : tree_d[s];
      tree_d[s] = (idle && acc_valid_i && acc_set_i == SW'(s)) ? touch(tree_d[s], acc_way_i) : tree_d[s];
    end
  end

  // state, flush counter and tree storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= idle ? '0 : cnt_q + 1'b1;
      for (int s = 0; s < SETS; s++) tree_q[s] <= tree_d[s];
    end
  end

  // response register holds its payload until the consumer takes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_way_o   <= '0;
      rsp_none_o  <= 1'b0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_way_o   <= victim;
      rsp_none_o  <= none;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_plru_set_array.sv
// tb_plru_set_array: directed and randomized checks of plru_set_array against a range-based PLRU model
module tb_plru_set_array;
  localparam int SETS = 4;
  localparam int WAYS = 4;
  logic       clk = 1'b0, rst_ni = 1'b0;
  logic       acc_valid, req_valid, req_ready, rsp_valid, rsp_ready, rsp_none, flush, flush_busy;
  logic [1:0] acc_set, acc_way, req_set, rsp_way;
  logic [3:0] vmask, lmask;
  int         checks = 0, passed = 0;
  bit         mtree [SETS][WAYS-1];
  bit         m_flush, m_rv, m_none;
  int         m_cnt, m_way;

  always #5 clk = ~clk;

  plru_set_array #(.SETS(SETS), .WAYS(WAYS), .UPDATE_ON_REPLACE(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .acc_valid_i(acc_valid), .acc_set_i(acc_set), .acc_way_i(acc_way),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_set_i(req_set),
    .req_valid_mask_i(vmask), .req_lock_mask_i(lmask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_way_o(rsp_way), .rsp_none_o(rsp_none),
    .flush_i(flush), .flush_busy_o(flush_busy)
  );

  function automatic bit all_locked(int lo, int hi, logic [WAYS-1:0] lk);
    for (int w = lo; w < hi; w++) if (!lk[w]) return 1'b0;
    return 1'b1;
  endfunction

  // -1 means every way is locked
  function automatic int ref_victim(int s, logic [WAYS-1:0] vm, logic [WAYS-1:0] lk);
    int lo, hi, n, mid;
    bit right;
    if (&lk) return -1;
    for (int w = 0; w < WAYS; w++) if (!vm[w] && !lk[w]) return w;
    lo = 0; hi = WAYS; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      right = mtree[s][n];
      if (right ? all_locked(mid, hi, lk) : all_locked(lo, mid, lk)) right = !right;
      if (right) begin lo = mid; n = 2 * n + 2; end
      else begin hi = mid; n = 2 * n + 1; end
    end
    return lo;
  endfunction

  function automatic void ref_touch(int s, int w);
    int lo, hi, n, mid;
    lo = 0; hi = WAYS; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin mtree[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
      else begin mtree[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) for (int n = 0; n < WAYS - 1; n++) mtree[s][n] = 1'b0;
    m_flush = 0; m_cnt = 0; m_rv = 0; m_none = 0; m_way = 0;
  endfunction

  function automatic bit m_ready();
    return !m_flush && (!m_rv || rsp_ready);
  endfunction

  task automatic idle_inputs();
    acc_valid = 0; acc_set = 0; acc_way = 0; req_valid = 0; req_set = 0;
    vmask = 4'hF; lmask = 4'h0; rsp_ready = 1; flush = 0;
  endtask

  task automatic tick();
    int  v;
    bit  was_flush, acc_ok;
    was_flush = m_flush;
    acc_ok = acc_valid && !was_flush;
    v = -2;
    if (req_valid && m_ready()) v = ref_victim(int'(req_set), vmask, lmask);
    @(posedge clk);
    if (!rst_ni) model_clear();
    else begin
      if (was_flush) begin
        for (int n = 0; n < WAYS - 1; n++) mtree[m_cnt][n] = 1'b0;
        if (m_cnt == SETS - 1) m_flush = 0;
        m_cnt = (m_cnt + 1) % SETS;
      end else if (flush) m_flush = 1;
      if (v >= 0) ref_touch(int'(req_set), v);
      if (acc_ok) ref_touch(int'(acc_set), int'(acc_way));
      if (v != -2) begin m_rv = 1; m_none = (v == -1); m_way = (v < 0) ? 0 : v; end
      else if (rsp_ready) m_rv = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    idle_inputs();
    model_clear();
    tick(); tick();
    rst_ni = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if (rsp_way !== 2'd0) $display("FAIL reset_rsp_way: got %0d want 0", rsp_way); else passed++;
    checks++; if (rsp_none !== 1'b0) $display("FAIL reset_rsp_none: got %b want 0", rsp_none); else passed++;
    checks++; if (flush_busy !== 1'b0) $display("FAIL reset_flush_busy: got %b want 0", flush_busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int exp [5] = '{0, 2, 1, 3, 0};
    do_reset();
    req_valid = 1; req_set = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, rsp_valid); else passed++;
      checks++; if (int'(rsp_way) !== exp[i]) $display("FAIL b2b_way[%0d]: got %0d want %0d", i, rsp_way, exp[i]); else passed++;
      checks++; if (rsp_none !== 1'b0) $display("FAIL b2b_none[%0d]: got %b want 0", i, rsp_none); else passed++;
      checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); else passed++;
    end
    req_valid = 0;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", rsp_valid); else passed++;
  endtask

  task automatic test_access();
    int ways [3] = '{2, 0, 1};
    do_reset();
    acc_valid = 1; acc_set = 1;
    for (int i = 0; i < 3; i++) begin acc_way = 2'(ways[i]); tick(); end
    acc_valid = 0; req_valid = 1; req_set = 1;
    tick();
    req_valid = 0;
    checks++; if (rsp_way !== 2'd3) $display("FAIL access_victim: got %0d want 3", rsp_way); else passed++;
  endtask

  task automatic test_invalid();
    do_reset();
    req_valid = 1; req_set = 0; vmask = 4'b1011;
    tick();
    checks++; if (rsp_way !== 2'd2) $display("FAIL invalid_first: got %0d want 2", rsp_way); else passed++;
    lmask = 4'b0100;
    tick();
    req_valid = 0;
    checks++; if (rsp_way !== 2'd0) $display("FAIL invalid_locked_walk: got %0d want 0", rsp_way); else passed++;
  endtask

  task automatic test_lock();
    do_reset();
    req_valid = 1; req_set = 0; lmask = 4'b0011;
    tick();
    checks++; if (rsp_way !== 2'd2) $display("FAIL lock_skip: got %0d want 2", rsp_way); else passed++;
    lmask = 4'b1111;
    tick();
    checks++; if (rsp_none !== 1'b1) $display("FAIL lock_all_none: got %b want 1", rsp_none); else passed++;
    checks++; if (rsp_way !== 2'd0) $display("FAIL lock_all_way: got %0d want 0", rsp_way); else passed++;
    lmask = 4'b0000;
    tick();
    req_valid = 0;
    checks++; if (rsp_none !== 1'b0) $display("FAIL lock_after_none: got %b want 0", rsp_none); else passed++;
    checks++; if (int'(rsp_way) !== m_way || rsp_way !== 2'd0) $display("FAIL lock_after_way: got %0d want 0", rsp_way); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 1; req_set = 0; rsp_ready = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid); else passed++;
      checks++; if (rsp_way !== 2'd0) $display("FAIL bp_way[%0d]: got %0d want 0", i, rsp_way); else passed++;
      checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, req_ready); else passed++;
      tick();
    end
    rsp_ready = 1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", req_ready); else passed++;
    tick();
    req_valid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_way !== 2'd2) $display("FAIL bp_second: got valid %b way %0d want valid 1 way 2", rsp_valid, rsp_way); else passed++;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", rsp_valid); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    acc_valid = 1; acc_set = 2; acc_way = 0; tick();
    acc_way = 2; tick();
    acc_valid = 0; flush = 1; tick();
    flush = 0; req_valid = 1; req_set = 2;
    acc_valid = 1; acc_set = 2; acc_way = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (flush_busy !== 1'b1) $display("FAIL flush_busy[%0d]: got %b want 1", i, flush_busy); else passed++;
      checks++; if (req_ready !== 1'b0) $display("FAIL flush_ready[%0d]: got %b want 0", i, req_ready); else passed++;
      tick();
    end
    acc_valid = 0;
    checks++; if (flush_busy !== 1'b0) $display("FAIL flush_end: got %b want 0", flush_busy); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL flush_waiting: got %b want 0", rsp_valid); else passed++;
    tick();
    req_valid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_way !== 2'd0) $display("FAIL flush_victim: got valid %b way %0d want valid 1 way 0", rsp_valid, rsp_way); else passed++;
  endtask

  task automatic test_reset_flush();
    do_reset();
    acc_valid = 1; acc_set = 1; acc_way = 0; tick();
    acc_set = 3; acc_way = 1; tick();
    acc_valid = 0; flush = 1; tick();
    flush = 0; tick();
    rst_ni = 0;
    #1;
    checks++; if (flush_busy !== 1'b0) $display("FAIL rstflush_busy: got %b want 0", flush_busy); else passed++;
    model_clear();
    tick();
    rst_ni = 1;
    tick();
    req_valid = 1;
    for (int s = 0; s < SETS; s++) begin
      req_set = 2'(s);
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_way !== 2'd0) $display("FAIL rstflush_set%0d: got valid %b way %0d want valid 1 way 0", s, rsp_valid, rsp_way); else passed++;
    end
    req_valid = 0;
    tick();
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      acc_valid = 1'($urandom_range(0, 1)); acc_set = 2'($urandom); acc_way = 2'($urandom);
      req_valid = 1'($urandom_range(0, 2) != 0); req_set = 2'($urandom);
      vmask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      lmask = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      flush = 1'($urandom_range(0, 39) == 0);
      exp_rdy = m_ready();
      #1;
      checks++; if (req_ready !== exp_rdy) $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); else passed++;
      tick();
      checks++; if (rsp_valid !== m_rv) $display("FAIL rnd_valid[%0d]: got %b want %b", c, rsp_valid, m_rv); else passed++;
      checks++; if (int'(rsp_way) !== m_way) $display("FAIL rnd_way[%0d]: got %0d want %0d", c, rsp_way, m_way); else passed++;
      checks++; if (rsp_none !== m_none) $display("FAIL rnd_none[%0d]: got %b want %b", c, rsp_none, m_none); else passed++;
      checks++; if (flush_busy !== m_flush) $display("FAIL rnd_busy[%0d]: got %b want %b", c, flush_busy, m_flush); else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_back_to_back();
    test_access();
    test_invalid();
    test_lock();
    test_backpressure();
    test_flush();
    test_reset_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
